// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the load/store initiator (mem_access_unit) and its
// request decoder (mem_req_decode).
//   - MODE_* : 3-bit access mode understood by the unified data memory
//   - FLT_*  : 2-bit fault code returned with every response
//   - state_e: control FSM states of mem_access_unit
// ---------------------------------------------------------------------------
package mem_pkg;

  // Memory access modes; the memory sign/zero-extends read data itself.
  localparam logic [2:0] MODE_W  = 3'b000;  // word
  localparam logic [2:0] MODE_HU = 3'b001;  // unsigned halfword
  localparam logic [2:0] MODE_BU = 3'b010;  // unsigned byte
  localparam logic [2:0] MODE_HS = 3'b011;  // signed halfword
  localparam logic [2:0] MODE_BS = 3'b100;  // signed byte

  // Response fault codes.
  localparam logic [1:0] FLT_OK    = 2'b00;
  localparam logic [1:0] FLT_F3    = 2'b01;  // illegal funct3
  localparam logic [1:0] FLT_RANGE = 2'b10;  // access not entirely below MEM_BYTES
  localparam logic [1:0] FLT_ALIGN = 2'b11;  // misaligned (trap build only)

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_access_unit_if.sv
// ---------------------------------------------------------------------------
// mem_access_unit_if
// Bundles the three handshakes of mem_access_unit:
//   req_* : request from the execute stage (valid/ready)
//   mem_* : port to the unified byte-addressed memory
//   rsp_* : response to the write-back side (valid/ready)
// Modports:
//   slave  : the mem_access_unit itself
//   master : the environment (execute stage, memory, response consumer)
// ---------------------------------------------------------------------------
interface mem_access_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_base;
  logic [31:0] req_imm;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_mode;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic [1:0]  rsp_fault;

  modport slave (
    input  req_valid, req_store, req_funct3, req_base, req_imm, req_wdata, req_rd,
    output req_ready,
    output mem_read, mem_write, mem_mode, mem_addr, mem_wdata,
    input  mem_rdata,
    output rsp_valid, rsp_data, rsp_rd, rsp_fault,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_store, req_funct3, req_base, req_imm, req_wdata, req_rd,
    input  req_ready,
    input  mem_read, mem_write, mem_mode, mem_addr, mem_wdata,
    output mem_rdata,
    input  rsp_valid, rsp_data, rsp_rd, rsp_fault,
    output rsp_ready
  );

endinterface

// File: rtl/mem_req_decode.sv
// ---------------------------------------------------------------------------
// mem_req_decode
// Purely combinational request decode for mem_access_unit.
//   store  : 1 = store, 0 = load
//   funct3 : RISC-V funct3 of the access
//   base   : rs1 value
//   imm    : sign-extended offset
//   ea     : effective address base + imm (mod 2^32)
//   mode   : memory access mode (MODE_*)
//   fault  : FLT_* code, priority illegal funct3 > range > alignment
// Optional feature: define MISALIGN_TRAP_EN to fault misaligned halfword and
// word accesses with FLT_ALIGN; otherwise they are passed to the memory.
// ---------------------------------------------------------------------------
module mem_req_decode
  import mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [31:0] base,
  input  logic [31:0] imm,
  output logic [31:0] ea,
  output logic [2:0]  mode,
  output logic [1:0]  fault
);

  localparam logic [33:0] LIMIT = 34'(MEM_BYTES);

  logic       legal;
  logic [2:0] size;
  logic [33:0] ea_wide;
  logic [33:0] last_byte;
  logic       out_of_range;
  logic       misaligned;

  // NOTE: every variable assigned in a combinational block gets a default
  // first, so no path through the case statements can infer a latch.
  always_comb begin
    legal = 1'b1;
    mode  = MODE_W;
    size  = 3'd4;
    if (store) begin
      case (funct3)
        3'b000:  begin mode = MODE_BU; size = 3'd1; end
        3'b001:  begin mode = MODE_HU; size = 3'd2; end
        3'b010:  begin mode = MODE_W;  size = 3'd4; end
        default: legal = 1'b0;
      endcase
    end else begin
      case (funct3)
        3'b000:  begin mode = MODE_BS; size = 3'd1; end
        3'b001:  begin mode = MODE_HS; size = 3'd2; end
        3'b010:  begin mode = MODE_W;  size = 3'd4; end
        3'b100:  begin mode = MODE_BU; size = 3'd1; end
        3'b101:  begin mode = MODE_HU; size = 3'd2; end
        default: legal = 1'b0;
      endcase
    end
  end

  // The offset is signed, so the sum is formed in two's complement with two
  // guard bits: bit 33 set means the address wrapped below zero, and a carry
  // into bit 32 means it wrapped past 2^32. Both count as out of range.
  assign ea_wide      = {2'b00, base} + {{2{imm[31]}}, imm};
  assign ea           = ea_wide[31:0];
  assign last_byte    = ea_wide + {31'd0, size} - 34'd1;
  assign out_of_range = ea_wide[33] | (last_byte >= LIMIT);

`ifdef MISALIGN_TRAP_EN
  assign misaligned = ((size == 3'd2) && ea[0]) ||
                      ((size == 3'd4) && (ea[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    fault = FLT_OK;
    if (!legal)            fault = FLT_F3;
    else if (out_of_range) fault = FLT_RANGE;
    else if (misaligned)   fault = FLT_ALIGN;
  end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// MEM-stage load/store initiator. Accepts one request at a time, computes the
// effective address, drives the memory port for MEM_LAT cycles and returns
// load data, store completion or a fault code.
// Parameters:
//   MEM_BYTES : memory size in bytes; accesses must lie entirely below it
//   MEM_LAT   : cycles the memory port is driven before mem_rdata is sampled
//               (1..15)
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : mem_access_unit_if.slave (req_*, mem_*, rsp_* handshakes)
// Optional feature: MISALIGN_TRAP_EN (see mem_req_decode).
// ---------------------------------------------------------------------------
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096,
  parameter int unsigned MEM_LAT   = 1
) (
  input  logic                clk,
  input  logic                rst,
  mem_access_unit_if.slave    bus
);

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_e      state;
  state_e      state_nxt;
  logic [3:0]  cnt;
  logic        is_store;
  logic        accept;

  logic [31:0] dec_ea;
  logic [2:0]  dec_mode;
  logic [1:0]  dec_fault;

  mem_req_decode #(
    .MEM_BYTES (MEM_BYTES)
  ) u_decode (
    .store  (bus.req_store),
    .funct3 (bus.req_funct3),
    .base   (bus.req_base),
    .imm    (bus.req_imm),
    .ea     (dec_ea),
    .mode   (dec_mode),
    .fault  (dec_fault)
  );

  assign accept = (state == ST_IDLE) && bus.req_valid;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (bus.req_valid)
                   state_nxt = (dec_fault != FLT_OK) ? ST_RESP : ST_ACCESS;
      ST_ACCESS: if (cnt == 4'd0) state_nxt = ST_RESP;
      ST_RESP:   if (bus.rsp_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Handshake and strobe outputs decode only the state register and the
  // latched store flag, so an asynchronous reset drops the strobes at once
  // and nothing on req_* reaches mem_* combinationally.
  always_comb begin
    bus.req_ready = (state == ST_IDLE);
    bus.rsp_valid = (state == ST_RESP);
    bus.mem_read  = (state == ST_ACCESS) && !is_store;
    bus.mem_write = (state == ST_ACCESS) &&  is_store;
  end

  // Datapath registers. A faulting request leaves the memory-side registers
  // at their previous values since it never reaches the memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= 4'd0;
      is_store      <= 1'b0;
      bus.mem_mode  <= 3'd0;
      bus.mem_addr  <= 32'd0;
      bus.mem_wdata <= 32'd0;
      bus.rsp_data  <= 32'd0;
      bus.rsp_rd    <= 5'd0;
      bus.rsp_fault <= FLT_OK;
    end else if (accept) begin
      is_store      <= bus.req_store;
      bus.rsp_rd    <= bus.req_rd;
      bus.rsp_fault <= dec_fault;
      bus.rsp_data  <= 32'd0;
      if (dec_fault == FLT_OK) begin
        cnt          <= CNT_INIT;
        bus.mem_addr <= dec_ea;
        bus.mem_mode <= dec_mode;
        if (bus.req_store) bus.mem_wdata <= bus.req_wdata;
      end
    end else if (state == ST_ACCESS) begin
      if (cnt == 4'd0) begin
        if (!is_store) bus.rsp_data <= bus.mem_rdata;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
// Self-checking bench for mem_access_unit: directed cases followed by random
// loads/stores, each compared against a reference model that derives the
// effective address, fault code, mode and load result from plain arithmetic
// on a byte array. A separate byte-array memory answers the DUT's port.
// Honours MISALIGN_TRAP_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

  localparam int MEM_BYTES = 4096;
  localparam int MEM_AW    = 12;
  localparam int LAT       = 3;

  logic clk;
  logic rst;

  mem_access_unit_if bus ();

  mem_access_unit #(
    .MEM_BYTES (MEM_BYTES),
    .MEM_LAT   (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 7 + 3) ^ (i >> 3));
  endfunction

  // ---------------- environment memory (answers the DUT) ----------------
  logic [7:0] env_mem [0:MEM_BYTES-1];

  function automatic logic [31:0] env_read(input logic [31:0] a, input logic [2:0] m);
    logic [31:0] w;
    logic [31:0] idx;
    for (int i = 0; i < 4; i++) begin
      idx = (a + 32'(i)) % 32'(MEM_BYTES);
      w[8*i +: 8] = env_mem[idx[MEM_AW-1:0]];
    end
    case (m)
      3'b001:  return {16'd0, w[15:0]};
      3'b010:  return {24'd0, w[7:0]};
      3'b011:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {{24{w[7]}}, w[7:0]};
      default: return w;
    endcase
  endfunction

  always @(negedge clk) bus.mem_rdata <= env_read(bus.mem_addr, bus.mem_mode);

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_BYTES; i++) env_mem[i] <= init_byte(i);
    end else if (bus.mem_write) begin
      int nb;
      logic [31:0] idx;
      nb = (bus.mem_mode == 3'b000) ? 4 :
           (bus.mem_mode == 3'b001 || bus.mem_mode == 3'b011) ? 2 : 1;
      for (int i = 0; i < nb; i++) begin
        idx = (bus.mem_addr + 32'(i)) % 32'(MEM_BYTES);
        env_mem[idx[MEM_AW-1:0]] <= bus.mem_wdata[8*i +: 8];
      end
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [0:MEM_BYTES-1];

  function automatic void predict(input logic st, input logic [2:0] f3,
                                  input logic [31:0] base, input logic [31:0] imm,
                                  output logic [1:0] flt, output logic [2:0] mode,
                                  output int size, output logic [31:0] ea);
    longint e;
    logic legal;
    legal = 1'b1; mode = 3'd0; size = 0;
    if (st) begin
      case (f3)
        3'd0: begin mode = 3'b010; size = 1; end
        3'd1: begin mode = 3'b001; size = 2; end
        3'd2: begin mode = 3'b000; size = 4; end
        default: legal = 1'b0;
      endcase
    end else begin
      case (f3)
        3'd0: begin mode = 3'b100; size = 1; end
        3'd1: begin mode = 3'b011; size = 2; end
        3'd2: begin mode = 3'b000; size = 4; end
        3'd4: begin mode = 3'b010; size = 1; end
        3'd5: begin mode = 3'b001; size = 2; end
        default: legal = 1'b0;
      endcase
    end
    e  = longint'({32'd0, base}) + longint'($signed(imm));
    ea = e[31:0];
    if (!legal)                                 flt = 2'd1;
    else if (e < 0 || e + size > MEM_BYTES)     flt = 2'd2;
`ifdef MISALIGN_TRAP_EN
    else if (e % size != 0)                     flt = 2'd3;
`endif
    else                                        flt = 2'd0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] ea);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = ref_mem[(int'(ea) + i) % MEM_BYTES];
    case (f3)
      3'd0:    return {{24{v[7]}}, v[7:0]};
      3'd1:    return {{16{v[15]}}, v[15:0]};
      3'd4:    return {24'd0, v[7:0]};
      3'd5:    return {16'd0, v[15:0]};
      default: return v;
    endcase
  endfunction

  // ---------------- one request/response transaction ----------------
  task automatic do_req(input logic st, input logic [2:0] f3,
                        input logic [31:0] base, input logic [31:0] imm,
                        input logic [31:0] wdata, input logic [4:0] rd,
                        input int hold,
                        output logic [31:0] got_data, output logic [1:0] got_fault);
    logic [1:0]  exp_flt;
    logic [2:0]  exp_mode;
    int          size;
    logic [31:0] ea;
    logic [31:0] exp_data;
    int lat, rd_cyc, wr_cyc, bad;
    logic ok;

    predict(st, f3, base, imm, exp_flt, exp_mode, size, ea);
    ok = (exp_flt == 2'd0);
    exp_data = (ok && !st) ? ref_load(f3, ea) : 32'd0;

    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_store = st; bus.req_funct3 = f3;
    bus.req_base = base; bus.req_imm = imm; bus.req_wdata = wdata; bus.req_rd = rd;
    bus.rsp_ready = 1'b0;
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1; rd_cyc = 0; wr_cyc = 0; bad = 0;
    while (!bus.rsp_valid && lat < 64) begin
      rd_cyc += int'(bus.mem_read);
      wr_cyc += int'(bus.mem_write);
      if ((bus.mem_read || bus.mem_write) &&
          (bus.mem_addr != ea || bus.mem_mode != exp_mode ||
           (st && bus.mem_wdata != wdata)))
        bad++;
      @(negedge clk);
      lat++;
    end
    check("rsp_arrived",  32'(bus.rsp_valid), 32'd1);
    check("latency",      32'(lat), ok ? 32'(LAT + 1) : 32'd1);
    check("read_cycles",  32'(rd_cyc), (ok && !st) ? 32'(LAT) : 32'd0);
    check("write_cycles", 32'(wr_cyc), (ok &&  st) ? 32'(LAT) : 32'd0);
    check("port_fields",  32'(bad), 32'd0);
    check("strobes_resp", 32'({bus.mem_read, bus.mem_write}), 32'd0);
    check("rsp_fault",    32'(bus.rsp_fault), 32'(exp_flt));
    check("rsp_rd",       32'(bus.rsp_rd), 32'(rd));
    check("rsp_data",     bus.rsp_data, exp_data);
    got_data  = bus.rsp_data;
    got_fault = bus.rsp_fault;

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("hold_data",  bus.rsp_data, exp_data);
      check("hold_ready", 32'(bus.req_ready), 32'd0);
    end

    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("rsp_done_valid", 32'(bus.rsp_valid), 32'd0);
    check("rsp_done_ready", 32'(bus.req_ready), 32'd1);

    if (ok && st)
      for (int i = 0; i < size; i++)
        ref_mem[(int'(ea) + i) % MEM_BYTES] = wdata[8*i +: 8];
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    logic [1:0]  f;

    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = init_byte(i);

    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_base = 32'd0; bus.req_imm = 32'd0; bus.req_wdata = 32'd0;
    bus.req_rd = 5'd0; bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_mem_read",  32'(bus.mem_read),  32'd0);
    check("rst_mem_write", 32'(bus.mem_write), 32'd0);
    check("rst_mem_mode",  32'(bus.mem_mode),  32'd0);
    check("rst_mem_addr",  bus.mem_addr,       32'd0);
    check("rst_mem_wdata", bus.mem_wdata,      32'd0);
    check("rst_rsp_data",  bus.rsp_data,       32'd0);
    check("rst_rsp_rd",    32'(bus.rsp_rd),    32'd0);
    check("rst_rsp_fault", 32'(bus.rsp_fault), 32'd0);
    rst = 1'b0;

    // Word store then load at 0x104.
    do_req(1'b1, 3'd2, 32'h100, 32'd4, 32'h11223344, 5'd1, 0, d, f);
    do_req(1'b0, 3'd2, 32'h100, 32'd4, 32'd0, 5'd2, 0, d, f);
    check("lw_data", d, 32'h11223344);

    // Byte 0x80: signed and unsigned loads.
    do_req(1'b1, 3'd0, 32'h300, 32'd0, 32'h00000080, 5'd3, 0, d, f);
    do_req(1'b0, 3'd0, 32'h300, 32'd0, 32'd0, 5'd4, 0, d, f);
    check("lb_data", d, 32'hFFFFFF80);
    do_req(1'b0, 3'd4, 32'h300, 32'd0, 32'd0, 5'd5, 0, d, f);
    check("lbu_data", d, 32'h00000080);

    // Halfword store, unsigned read-back.
    do_req(1'b1, 3'd1, 32'h200, 32'd0, 32'hAABBCCDD, 5'd6, 0, d, f);
    do_req(1'b0, 3'd5, 32'h200, 32'd0, 32'd0, 5'd7, 0, d, f);
    check("lhu_data", d, 32'h0000CCDD);

    // Range boundary and wrap.
    do_req(1'b0, 3'd2, 32'hFFC, 32'd0, 32'd0, 5'd8, 0, d, f);
    check("lw_top_fault", 32'(f), 32'd0);
    do_req(1'b0, 3'd2, 32'hFFD, 32'd0, 32'd0, 5'd9, 0, d, f);
    check("lw_over_fault", 32'(f), 32'd2);
    do_req(1'b0, 3'd0, 32'hFFFFFFFF, 32'd2, 32'd0, 5'd10, 0, d, f);
    check("wrap_fault", 32'(f), 32'd2);

    // Illegal funct3 and misalignment.
    do_req(1'b0, 3'd3, 32'h100, 32'd0, 32'd0, 5'd11, 0, d, f);
    check("f3_fault", 32'(f), 32'd1);
    do_req(1'b0, 3'd2, 32'h100, 32'd2, 32'd0, 5'd12, 0, d, f);
`ifdef MISALIGN_TRAP_EN
    check("misalign_fault", 32'(f), 32'd3);
`else
    check("misalign_fault", 32'(f), 32'd0);
`endif

    // Consumer back-pressure for 5 cycles.
    do_req(1'b0, 3'd2, 32'h100, 32'd4, 32'd0, 5'd13, 5, d, f);

    // Asynchronous reset in the middle of a load's access window.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_store = 1'b0; bus.req_funct3 = 3'd2;
    bus.req_base = 32'h104; bus.req_imm = 32'd0; bus.req_rd = 5'd14;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("pre_rst_read", 32'(bus.mem_read), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_read",  32'(bus.mem_read),  32'd0);
    check("mid_rst_write", 32'(bus.mem_write), 32'd0);
    check("mid_rst_ready", 32'(bus.req_ready), 32'd1);
    check("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(bus.req_ready), 32'd1);
    check("post_rst_read",  32'(bus.mem_read),  32'd0);

    // Random traffic.
    for (int n = 0; n < 80; n++) begin
      logic        st;
      logic [2:0]  f3;
      logic [31:0] base, imm;
      st   = ($urandom_range(0, 2) == 0);
      f3   = 3'($urandom_range(0, 7));
      base = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, 'h1010));
      imm  = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($signed($urandom_range(0, 255)) - 128);
      do_req(st, f3, base, imm, $urandom(), 5'($urandom_range(0, 31)),
             $urandom_range(0, 2), d, f);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator between the execute stage and the unified byte-addressed data/instruction memory. Accepts one load or store request at a time over a valid/ready handshake, computes the effective address and translates RISC-V funct3 into the memory's 3-bit access mode. It drives the memory port for a fixed number of wait cycles and returns load data, store completion or a fault over a valid/ready response handshake. Sits in the MEM stage; the core stalls while `req_ready` is low.

## Interface
- `MEM_BYTES`, 4096: memory size in bytes; the access must lie entirely below this.
- `MEM_LAT`, 1: cycles between driving the memory port and sampling `mem_rdata` (1..15).
- `clk` input 1: clock; all state updates on rising edge.
- `rst` input 1: reset rst, asynchronous, active-high.
- `req_valid` input 1: request present.
- `req_ready` output 1: unit can accept a request; high only in IDLE.
- `req_store` input 1: 1 = store, 0 = load.
- `req_funct3` input 3: RISC-V funct3 of the load or store.
- `req_base` input 32: rs1 value.
- `req_imm` input 32: sign-extended offset.
- `req_wdata` input 32: store data (rs2).
- `req_rd` input 5: destination register tag; returned with the response.
- `mem_read` output 1: memory read strobe.
- `mem_write` output 1: memory write strobe.
- `mem_mode` output 3: 000 word, 001 unsigned halfword, 010 unsigned byte, 011 signed halfword, 100 signed byte.
- `mem_addr` output 32: byte address.
- `mem_wdata` output 32: store data.
- `mem_rdata` input 32: memory read data, already extended by the memory.
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: consumer accepts the response.
- `rsp_data` output 32: load result; 0 for stores and faults.
- `rsp_rd` output 5: echoed `req_rd`.
- `rsp_fault` output 2: 00 ok, 01 illegal funct3, 10 access out of range, 11 misaligned.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE:** `req_ready` = 1. When `req_valid` is high, latch all request fields, compute `ea = req_base + req_imm` (mod 2^32) and decode:
  - Load funct3 mapping: 000 → 100, 001 → 011, 010 → 000, 100 → 010, 101 → 001.
  - Store funct3 mapping: 000 → 010, 001 → 001, 010 → 000.
  - Any other funct3 is an illegal-funct3 fault.
- **Fault checks, in priority order:** illegal funct3, then range (`ea + size - 1 >= MEM_BYTES`, computed with 33-bit arithmetic so address wrap counts as out of range), then misalignment (only if `MISALIGN_TRAP_EN` is defined).
  - Faulting request: go directly to RESP with the fault code.
  - Otherwise: go to ACCESS and load the wait counter with `MEM_LAT - 1`.
- **ACCESS:** drive `mem_read` or `mem_write`, `mem_mode`, `mem_addr = ea` and `mem_wdata` for exactly `MEM_LAT` cycles.
  - `mem_write` is held for the whole window; the memory commits the store within it.
  - When the counter reaches 0, capture `mem_rdata` (loads) into `rsp_data` and go to RESP.
- **RESP:** `rsp_valid` = 1 and holds until `rsp_ready`. On the handshake, return to IDLE. A new request is accepted no earlier than the next cycle.
- Memory strobes are 0 outside ACCESS. `mem_addr`, `mem_mode` and `mem_wdata` hold their last values.

## Timing
- Reset values:
  - State: IDLE.
  - `req_ready` = 1; `rsp_valid` = 0; `mem_read` = 0; `mem_write` = 0.
  - `mem_mode` = 0; `mem_addr` = 0; `mem_wdata` = 0; `rsp_data` = 0; `rsp_rd` = 0; `rsp_fault` = 0.
- Good access latency: accept at edge N; ACCESS during cycles N+1..N+MEM_LAT; `rsp_valid` from cycle N+MEM_LAT+1.
- Faulting request: `rsp_valid` in cycle N+1; no memory strobe at any time.
- Reset mid-ACCESS: strobes drop immediately (asynchronous). A partially written store is not retried.
- `rsp_ready` held low: the response is held stable; `req_ready` stays 0.
- All outputs are registered; no combinational path from `req_*` to `mem_*`.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - Halfword at an odd address, or word with `ea[1:0]` != 0, faults with code 11 and produces no memory access.
- `MISALIGN_TRAP_EN` undefined:
  - Misaligned accesses are passed to the memory unchanged (the memory is byte-addressed).
  - Code 11 is never produced.

## Structure
- Shared package `mem_pkg` holds:
  - Mode constants MODE_W, MODE_HU, MODE_BU, MODE_HS, MODE_BS.
  - Fault codes FLT_OK, FLT_F3, FLT_RANGE, FLT_ALIGN.
  - FSM state typedef.
- Sub-module `mem_req_decode`: combinational funct3 → mode/size decode plus range and alignment checks. The FSM and counter live in the top module.

## Test plan
- LW, base 0x100, imm 4, memory word 0x11223344 at 0x104, MEM_LAT = 1 → one read cycle with mode 000 and address 0x104; `rsp_data` 0x11223344, fault 00, two cycles after accept.
- LB at a byte holding 0x80 → mode 100, and the memory returns 0xFFFFFF80. LBU at the same byte → mode 010, `rsp_data` 0x00000080.
- SH, data 0xAABBCCDD, to 0x200, MEM_LAT = 3 → `mem_write` high for exactly 3 cycles with mode 001; a read-back LHU returns 0x0000CCDD.
- LW at 0xFFC with MEM_BYTES = 4096 → ok. LW at 0xFFD → fault 10 with no strobe. Base 0xFFFFFFFF with imm 2 → fault 10.
- Load with funct3 = 011 → fault 01. With `MISALIGN_TRAP_EN` defined, LW at 0x102 → fault 11; without it, the same access proceeds with fault 00.
- `rsp_ready` held low 5 cycles → response stable and `req_ready` low; asserting `rst` during ACCESS → strobes 0 immediately, state IDLE.
